flag_commit_unit: RTL and testbench
===================================

# flag_commit_unit

Execute-stage back end placed directly downstream of the ALU. It captures each ALU result together with its condition code, evaluates the ARM condition against the architectural NZCV register, updates NZCV on flag-setting instructions, and buffers passed results in a two-entry skid buffer toward register writeback. It also returns the current C flag to the ALU carry input for ADC/SBC/RSC.

## Interface
- CNT_W, 16, width of the condition-fail counter (saturating)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- flush  in  1  discard buffered results (branch redirect)
- in_valid  in  1  ALU result present
- in_ready  out  1  unit can accept; driven directly from a register
- in_cond  in  4  ARM condition field
- in_set_flags  in  1  S bit
- in_logical  in  1  opcode is logical class (AND/EOR/TST/TEQ/ORR/MOV/BIC/MVN)
- in_wb_en  in  1  instruction writes Rd (0 for TST/TEQ/CMP/CMN)
- in_rd  in  4  destination register
- in_result  in  32  ALU result
- in_flags  in  4  ALU flags {N,Z,C,V}, bit 3 = N, bit 0 = V
- in_shift_carry  in  1  barrel-shifter carry-out
- carry_out  out  1  current registered C flag, fed to the ALU carry input
- flags_q  out  4  architectural NZCV register
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback accepts the head entry
- out_data  out  32  head result
- out_rd  out  4  head destination
- out_we  out  1  head writes the register file
- cond_fail_count  out  CNT_W  instructions dropped on a failed condition

## Operation
- Accept event: in_valid & in_ready & ~flush.
- Condition evaluation uses flags_q in the accept cycle: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
- Pass & in_set_flags: flags_q updated at the accept edge, so the next accepted instruction sees the new flags with no bubble.
- Pass & (in_wb_en | in_set_flags): entry {in_result, in_rd, in_wb_en} pushed. Pass with neither bit set: nothing pushed.
- Fail: nothing pushed, flags unchanged, cond_fail_count += 1 (saturates at all-ones, no wrap).
- Buffer FSM, states EMPTY, ONE, TWO:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push & pop -> ONE.
  - TWO: pop -> ONE. Push is impossible because in_ready = 0.
- pop = out_valid & out_ready. in_ready = (state != TWO). out_valid = (state != EMPTY).
- Head ordering: head is the oldest entry. On pop from TWO, the second entry moves to the head.
- flush takes priority over all other events:
  - next state EMPTY.
  - A same-cycle push is discarded.
  - The same-cycle flag update and counter increment are suppressed.
  - Flags written by earlier accepted instructions persist.

## Timing
- Reset values:
  - flags_q = 0, carry_out = 0.
  - state EMPTY, out_valid = 0, out_data = 0, out_rd = 0, out_we = 0.
  - cond_fail_count = 0.
  - in_ready = 1 from the first cycle after reset.
- Latency: accept at edge N -> out_valid high after edge N.
- Result path is fully registered. No combinational path from in_* to out_*.
- Throughput: one accept per cycle while out_ready is held high.
- in_ready is registered. Deasserting out_ready stalls intake one cycle later, absorbed by the second entry.
- Reset mid-operation drops all entries and clears flags.

## Configuration
- LOGIC_CARRY_EN defined, for logical-class instructions with the S bit:
  - C is taken from in_shift_carry.
  - V keeps its old value (ARM semantics).
- LOGIC_CARRY_EN undefined: all four flags come from in_flags verbatim for every flag-setting instruction.
- Arithmetic instructions behave identically in both builds.

## Structure
- Shared package flag_pkg contains:
  - flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - cond_e enum of the 16 condition codes.
  - buf_state_e enum {EMPTY, ONE, TWO}.
- Sub-module cond_check: purely combinational, maps (cond, nzcv) -> pass. It is reused by branch logic.

## Test plan
- Reset, then ADDS: result 0x00000000, in_flags 0b0110, cond AL -> flags_q = 0b0110 next cycle; out_data 0, out_we 1, out_valid one cycle after accept.
- Back-to-back SUBS (flags 0b0100), then ADD with cond EQ -> second instruction pushed; with cond NE -> dropped and cond_fail_count = 1.
- out_ready low, three consecutive valid inputs -> first two buffered, in_ready low after the second, third held; out_ready high -> order preserved 1, 2, 3.
- flush asserted with in_valid and a set-flags instruction while state TWO -> state EMPTY, flags_q unchanged, out_valid 0 next cycle.
- ANDS, in_flags 0b0001, in_shift_carry 1, prior flags 0b0011:
  - LOGIC_CARRY_EN defined -> flags_q = 0b0011.
  - LOGIC_CARRY_EN undefined -> flags_q = 0b0001.
- CNT_W = 2, five failing instructions -> cond_fail_count saturates at 3.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared types for the execute-stage flag/commit back end and branch logic.
package flag_pkg;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [3:0] {
      CondEq = 4'b0000,
      CondNe = 4'b0001,
      CondCs = 4'b0010,
      CondCc = 4'b0011,
      CondMi = 4'b0100,
      CondPl = 4'b0101,
      CondVs = 4'b0110,
      CondVc = 4'b0111,
      CondHi = 4'b1000,
      CondLs = 4'b1001,
      CondGe = 4'b1010,
      CondLt = 4'b1011,
      CondGt = 4'b1100,
      CondLe = 4'b1101,
      CondAl = 4'b1110,
      CondNv = 4'b1111
   } cond_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_e;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  rd;
      logic        we;
   } wb_entry_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: (cond, nzcv) -> pass.
module cond_check
   import flag_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      unique case (cond_e'(cond))
         CondEq:  pass = z;
         CondNe:  pass = ~z;
         CondCs:  pass = c;
         CondCc:  pass = ~c;
         CondMi:  pass = n;
         CondPl:  pass = ~n;
         CondVs:  pass = v;
         CondVc:  pass = ~v;
         CondHi:  pass = c & ~z;
         CondLs:  pass = ~c | z;
         CondGe:  pass = (n == v);
         CondLt:  pass = (n != v);
         CondGt:  pass = ~z & (n == v);
         CondLe:  pass = z | (n != v);
         CondAl:  pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_commit_unit.sv
// Execute back end: condition check, NZCV update and two-entry writeback skid buffer.
// Optional LOGIC_CARRY_EN: logical-class S instructions take C from the shifter and keep V.
module flag_commit_unit
   import flag_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cond,
   input  logic             in_set_flags,
   input  logic             in_logical,
   input  logic             in_wb_en,
   input  logic [3:0]       in_rd,
   input  logic [31:0]      in_result,
   input  logic [3:0]       in_flags,
   input  logic             in_shift_carry,
   output logic             carry_out,
   output logic [3:0]       flags_q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [3:0]       out_rd,
   output logic             out_we,
   output logic [CNT_W-1:0] cond_fail_count
);

   buf_state_e       state_q, state_d;
   wb_entry_t        head_q, head_d;
   wb_entry_t        tail_q, tail_d;
   wb_entry_t        in_entry;
   logic             in_ready_q, in_ready_d;
   logic [3:0]       flags_d;
   logic [3:0]       new_flags;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pass, accept, push, pop;

   cond_check u_cond_check (
      .cond (in_cond),
      .nzcv (flags_q),
      .pass (pass)
   );

   assign accept   = in_valid & in_ready_q & ~flush;
   assign push     = accept & pass & (in_wb_en | in_set_flags);
   assign pop      = out_valid & out_ready;
   assign in_entry = '{data: in_result, rd: in_rd, we: in_wb_en};

`ifdef LOGIC_CARRY_EN
   always_comb begin
      new_flags = in_flags;
      if (in_logical) begin
         new_flags[FLAG_C] = in_shift_carry;
         new_flags[FLAG_V] = flags_q[FLAG_V];
      end
   end
`else
   logic unused_logic_inputs;
   assign unused_logic_inputs = in_logical ^ in_shift_carry;
   assign new_flags = in_flags;
`endif

   always_comb begin
      flags_d = flags_q;
      cnt_d   = cnt_q;
      if (accept && pass && in_set_flags) begin
         flags_d = new_flags;
      end
      if (accept && !pass && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Buffer next state; a flush overrides whatever push/pop decided.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      unique case (state_q)
         EMPTY: begin
            if (push) begin
               head_d  = in_entry;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_d = in_entry;
            end else if (push) begin
               tail_d  = in_entry;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
      end
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         in_ready_q <= 1'b1;
         flags_q    <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         in_ready_q <= in_ready_d;
         flags_q    <= flags_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = (state_q != EMPTY);
   assign out_data        = head_q.data;
   assign out_rd          = head_q.rd;
   assign out_we          = head_q.we;
   assign carry_out       = flags_q[FLAG_C];
   assign cond_fail_count = cnt_q;

endmodule

// File: tb/tb_flag_commit_unit.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_flag_commit_unit;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_set_flags, in_logical, in_wb_en, in_shift_carry;
   logic        out_ready;
   logic [3:0]  in_cond, in_rd, in_flags;
   logic [31:0] in_result;

   logic        in_ready, carry_out, out_valid, out_we;
   logic [3:0]  flags_q, out_rd;
   logic [31:0] out_data;
   logic [15:0] cnt16;

   logic        in_ready2, carry_out2, out_valid2, out_we2;
   logic [3:0]  flags_q2, out_rd2;
   logic [31:0] out_data2;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   flag_commit_unit #(.CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_cond(in_cond), .in_set_flags(in_set_flags), .in_logical(in_logical),
      .in_wb_en(in_wb_en), .in_rd(in_rd), .in_result(in_result), .in_flags(in_flags),
      .in_shift_carry(in_shift_carry), .carry_out(carry_out), .flags_q(flags_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_we(out_we), .cond_fail_count(cnt16)
   );

   flag_commit_unit #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_cond(in_cond), .in_set_flags(in_set_flags), .in_logical(in_logical),
      .in_wb_en(in_wb_en), .in_rd(in_rd), .in_result(in_result), .in_flags(in_flags),
      .in_shift_carry(in_shift_carry), .carry_out(carry_out2), .flags_q(flags_q2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_rd(out_rd2),
      .out_we(out_we2), .cond_fail_count(cnt2)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural flags, fail count and an ordered queue of pending writes.
   typedef struct {
      logic [31:0] d;
      logic [3:0]  rd;
      logic        we;
   } ent_t;

   ent_t       mq[$];
   logic [3:0] m_flags;
   int         m_cnt;

   function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hf) return 1'b0;
      return c[0] ? !base : base;
   endfunction

   function automatic logic [3:0] m_new_flags();
`ifdef LOGIC_CARRY_EN
      if (in_logical) return {in_flags[3:2], in_shift_carry, m_flags[0]};
`endif
      return in_flags;
   endfunction

   task automatic model_step();
      bit acc, ok;
      if (reset) begin
         mq.delete();
         m_flags = 4'h0;
         m_cnt   = 0;
      end else if (flush) begin
         mq.delete();
      end else begin
         acc = in_valid && (mq.size() < 2);
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (acc) begin
            ok = m_cond(in_cond, m_flags);
            if (!ok) m_cnt++;
            else begin
               if (in_wb_en || in_set_flags) mq.push_back('{in_result, in_rd, in_wb_en});
               if (in_set_flags) m_flags = m_new_flags();
            end
         end
      end
   endtask

   task automatic model_check();
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      if (mq.size() != 0) begin
         chk("out_data", out_data, mq[0].d);
         chk("out_rd", {28'd0, out_rd}, {28'd0, mq[0].rd});
         chk("out_we", {31'd0, out_we}, {31'd0, mq[0].we});
      end
      chk("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
      chk("carry_out", {31'd0, carry_out}, {31'd0, m_flags[1]});
      chk("cnt16", {16'd0, cnt16}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
      chk("cnt2", {30'd0, cnt2}, (m_cnt > 3) ? 32'd3 : m_cnt);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      model_check();
   endtask

   task automatic idle_inputs();
      reset = 0; flush = 0; in_valid = 0; in_set_flags = 0; in_logical = 0; in_wb_en = 0;
      in_shift_carry = 0; in_cond = 4'he; in_rd = 0; in_flags = 0; in_result = 0; out_ready = 1;
   endtask

   typedef struct {
      logic        valid, flush, ordy, set, lgc, wb, shc;
      logic [3:0]  cond, rd, fl;
      logic [31:0] res;
      logic [3:0]  e_flags;
      logic        e_valid, e_ready;
      logic [31:0] e_data;
      int          e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic f, input logic o, input logic s,
                               input logic l, input logic w, input logic sc, input logic [3:0] c,
                               input logic [3:0] rd, input logic [3:0] fl, input logic [31:0] r,
                               input logic [3:0] ef, input logic ev, input logic er,
                               input logic [31:0] ed, input int ec);
      vec_t t;
      t.valid = v; t.flush = f; t.ordy = o; t.set = s; t.lgc = l; t.wb = w; t.shc = sc;
      t.cond = c; t.rd = rd; t.fl = fl; t.res = r; t.e_flags = ef; t.e_valid = ev;
      t.e_ready = er; t.e_data = ed; t.e_cnt = ec;
      return t;
   endfunction

   localparam logic [3:0] AndsFlags =
`ifdef LOGIC_CARRY_EN
      4'b0011;
`else
      4'b0001;
`endif

   vec_t vecs[$];

   initial begin
      idle_inputs();
      reset = 1;
      cycle();
      reset = 0;
      cycle();
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_rd", {28'd0, out_rd}, 32'd0);
      chk("rst_out_we", {31'd0, out_we}, 32'd0);

      //          v  f  o  s  l  w  sc cond   rd  fl     res    eflags ev er edata  ecnt
      vecs.push_back(mk(1, 0, 1, 1, 0, 1, 0, 4'he, 1, 4'h6, 32'h0,  4'h6, 1, 1, 32'h0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 1, 0, 4'he, 2, 4'h4, 32'h5,  4'h4, 1, 1, 32'h5, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 4'h0, 3, 4'h0, 32'h7,  4'h4, 1, 1, 32'h7, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 4'h1, 4, 4'h0, 32'h9,  4'h4, 0, 1, 32'h0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'he, 0, 4'h0, 32'h0,  4'h4, 0, 1, 32'h0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4'he, 5, 4'h0, 32'h1,  4'h4, 1, 1, 32'h1, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4'he, 6, 4'h0, 32'h2,  4'h4, 1, 0, 32'h1, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4'he, 7, 4'h0, 32'h3,  4'h4, 1, 0, 32'h1, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 4'he, 7, 4'h0, 32'h3,  4'h4, 1, 1, 32'h2, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 4'he, 7, 4'h0, 32'h3,  4'h4, 1, 1, 32'h3, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'he, 0, 4'h0, 32'h0,  4'h4, 0, 1, 32'h0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4'he, 8, 4'h0, 32'hA,  4'h4, 1, 1, 32'hA, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4'he, 9, 4'h0, 32'hB,  4'h4, 1, 0, 32'hA, 1));
      vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 4'he, 9, 4'hf, 32'hC,  4'h4, 0, 1, 32'h0, 1));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 4'he, 0, 4'h3, 32'h15, 4'h3, 1, 1, 32'h15, 1));
      vecs.push_back(mk(1, 0, 1, 1, 1, 1, 1, 4'he, 1, 4'h1, 32'h16, AndsFlags, 1, 1, 32'h16, 1));
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 4'hf, 2, 4'h0, 32'h20, AndsFlags, 0, 1, 32'h0,
                           2 + i));
      end

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].valid; flush = vecs[i].flush; out_ready = vecs[i].ordy;
         in_set_flags = vecs[i].set; in_logical = vecs[i].lgc; in_wb_en = vecs[i].wb;
         in_shift_carry = vecs[i].shc; in_cond = vecs[i].cond; in_rd = vecs[i].rd;
         in_flags = vecs[i].fl; in_result = vecs[i].res;
         cycle();
         chk($sformatf("vec%0d_flags", i), {28'd0, flags_q}, {28'd0, vecs[i].e_flags});
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
         chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ready});
         if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
         chk($sformatf("vec%0d_cnt", i), {16'd0, cnt16}, vecs[i].e_cnt);
      end
      chk("cnt2_saturated", {30'd0, cnt2}, 32'd3);

      // Randomized traffic with occasional flush and mid-operation reset.
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 199) == 0);
         flush          = ($urandom_range(0, 15) == 0);
         in_valid       = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         in_set_flags   = $urandom_range(0, 1);
         in_logical     = $urandom_range(0, 1);
         in_wb_en       = $urandom_range(0, 1);
         in_shift_carry = $urandom_range(0, 1);
         in_cond        = 4'($urandom_range(0, 15));
         in_rd          = 4'($urandom_range(0, 15));
         in_flags       = 4'($urandom_range(0, 15));
         in_result      = $urandom;
         cycle();
      end

      idle_inputs();
      cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
